// File: rtl/fast_pkg.sv
// fast_pkg: ring geometry, offset tables and FSM states shared by the ring walker.
package fast_pkg;
    localparam int RING_N      = 16;
    localparam int RING_RADIUS = 3;
    typedef logic signed [2:0] ring_off_t;
    localparam ring_off_t DX [RING_N] = '{
        3'sd0, 3'sd1, 3'sd2, 3'sd3, 3'sd3, 3'sd3, 3'sd2, 3'sd1,
        3'sd0, -3'sd1, -3'sd2, -3'sd3, -3'sd3, -3'sd3, -3'sd2, -3'sd1
    };
    localparam ring_off_t DY [RING_N] = '{
        -3'sd3, -3'sd3, -3'sd2, -3'sd1, 3'sd0, 3'sd1, 3'sd2, 3'sd3,
        3'sd3, 3'sd3, 3'sd2, 3'sd1, 3'sd0, -3'sd1, -3'sd2, -3'sd3
    };
    typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_t;
endpackage

// File: rtl/ring_offset_lut.sv
// ring_offset_lut: combinational map from ring position to (dx,dy) offset.
import fast_pkg::*;

module ring_offset_lut (
    input  logic [3:0] idx_i,
    output ring_off_t  dx_o,
    output ring_off_t  dy_o
);
    assign dx_o = DX[idx_i];
    assign dy_o = DY[idx_i];
endmodule

// File: rtl/ring_walk_ctrl.sv
// ring_walk_ctrl: walks the 16-pixel radius-3 ring around each accepted candidate.
// Optional RING_BOUNDS_CHECK_EN rejects candidates whose ring leaves the image.
import fast_pkg::*;

module ring_walk_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    localparam int XW = $clog2(IMG_W),
    localparam int YW = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cand_valid,
    input  logic [XW-1:0] cand_x,
    input  logic [YW-1:0] cand_y,
    output logic          cand_ready,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [XW-1:0] rd_x,
    output logic [YW-1:0] rd_y,
    output logic [3:0]    rd_idx,
    output logic          rd_last,
    output logic          done,
    output logic          skip,
    output logic          busy
);
    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic          oob;
    ring_off_t     dx, dy;

    ring_offset_lut u_lut (.idx_i(idx_q), .dx_o(dx), .dy_o(dy));

    // Sign-extended add at the port width wraps modulo 2^XW / 2^YW.
    assign rd_x       = cx_q + XW'(dx);
    assign rd_y       = cy_q + YW'(dy);
    assign rd_idx     = idx_q;
    assign cand_ready = state_q == S_IDLE;
    assign rd_valid   = state_q == S_WALK;
    assign rd_last    = rd_valid && idx_q == 4'd15;
    assign done       = state_q == S_DONE;
    assign busy       = state_q != S_IDLE;

`ifdef RING_BOUNDS_CHECK_EN
    logic skip_q, skip_d;
    assign oob  = cand_x < XW'(RING_RADIUS) || cand_x > XW'(IMG_W - 1 - RING_RADIUS)
               || cand_y < YW'(RING_RADIUS) || cand_y > YW'(IMG_H - 1 - RING_RADIUS);
    assign skip = done && skip_q;
    always_comb skip_d = state_q == S_IDLE ? (cand_valid && oob) : skip_q;
    always_ff @(posedge clk) skip_q <= rst ? 1'b0 : skip_d;
`else
    assign oob  = 1'b0;
    assign skip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        unique case (state_q)
            S_IDLE: if (cand_valid) begin
                cx_d    = cand_x;
                cy_d    = cand_y;
                idx_d   = 4'd0;
                state_d = oob ? S_DONE : S_WALK;
            end
            S_WALK: if (rd_ready) begin
                state_d = idx_q == 4'd15 ? S_DONE : S_WALK;
                idx_d   = idx_q == 4'd15 ? 4'd0 : idx_q + 4'd1;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
        end
    end
endmodule

// File: tb/tb_ring_walk_ctrl.sv
// tb_ring_walk_ctrl: directed checks of the ring walker, default 640x480 geometry.
module tb_ring_walk_ctrl;
    localparam int XW = 10;
    localparam int YW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cand_valid = 1'b0;
    logic [XW-1:0] cand_x = '0;
    logic [YW-1:0] cand_y = '0;
    logic          cand_ready, rd_valid, rd_last, done, skip, busy;
    logic          rd_ready = 1'b1;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic [3:0]    rd_idx;

    int checks = 0;
    int errors = 0;
    int dx_t [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    int dy_t [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

    ring_walk_ctrl dut (
        .clk(clk), .rst(rst), .cand_valid(cand_valid), .cand_x(cand_x), .cand_y(cand_y),
        .cand_ready(cand_ready), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_x(rd_x),
        .rd_y(rd_y), .rd_idx(rd_idx), .rd_last(rd_last), .done(done), .skip(skip), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({rd_valid, rd_last, done, skip, busy, cand_ready, rd_idx} !== {6'b000001, 4'd0}) begin
            errors++;
            $display("FAIL reset: got %b required %b", {rd_valid, rd_last, done, skip, busy, cand_ready, rd_idx}, {6'b000001, 4'd0});
        end
    endtask

    // Presents a candidate for one accept edge; returns in cycle N+1.
    task automatic accept(input int x, input int y);
        cand_x = XW'(x);
        cand_y = YW'(y);
        cand_valid = 1'b1;
        step();
        cand_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic [XW+YW+7:0] got, exp;
        rd_ready = 1'b1;
        accept(100, 50);
        for (int i = 0; i < 16; i++) begin
            got = {rd_valid, rd_idx, rd_x, rd_y, rd_last, done, busy, cand_ready};
            exp = {1'b1, 4'(i), XW'(100 + dx_t[i]), YW'(50 + dy_t[i]), i == 15, 1'b0, 1'b1, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic idx%0d: got %h required %h", i, got, exp);
            end
            step();
        end
        checks++;
        if ({done, skip, rd_valid, cand_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL basic done: got %b required 1000", {done, skip, rd_valid, cand_ready});
        end
        step();
        checks++;
        if ({done, busy, cand_ready} !== 3'b001) begin
            errors++;
            $display("FAIL basic ready_again: got %b required 001", {done, busy, cand_ready});
        end
    endtask

    task automatic test_stall();
        logic [XW+YW+5:0] got, exp;
        int ndone = 0;
        rd_ready = 1'b0;
        accept(10, 10);
        for (int i = 0; i < 16; i++) begin
            for (int h = 0; h < 2; h++) begin
                rd_ready = h[0];
                #1;
                got = {rd_valid, rd_idx, rd_x, rd_y, rd_last, done};
                exp = {1'b1, 4'(i), XW'(10 + dx_t[i]), YW'(10 + dy_t[i]), i == 15, 1'b0};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL stall idx%0d phase%0d: got %h required %h", i, h, got, exp);
                end
                step();
            end
        end
        rd_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            ndone += int'(done);
            step();
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL stall done_count: got %0d required 1", ndone);
        end
    endtask

    task automatic test_back_to_back();
        int ndone = 0;
        rd_ready = 1'b1;
        cand_x = 10'd5;
        cand_y = 9'd6;
        cand_valid = 1'b1;
        step();
        cand_x = 10'd30;
        cand_y = 9'd40;
        for (int c = 0; c < 17; c++) begin
            ndone += int'(done);
            checks++;
            if (cand_ready !== 1'b0 || (c < 16 && (rd_x !== XW'(5 + dx_t[c]) || rd_idx !== 4'(c)))) begin
                errors++;
                $display("FAIL b2b first c%0d: got ready=%b x=%0d idx=%0d required ready=0 x=%0d idx=%0d", c, cand_ready, rd_x, rd_idx, 5 + dx_t[c % 16], c);
            end
            step();
        end
        checks++;
        if (cand_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b ready_return: got %b required 1", cand_ready);
        end
        step();
        cand_valid = 1'b0;
        for (int c = 0; c < 18; c++) begin
            ndone += int'(done);
            if (c < 16) begin
                checks++;
                if ({rd_valid, rd_idx, rd_x, rd_y} !== {1'b1, 4'(c), XW'(30 + dx_t[c]), YW'(40 + dy_t[c])}) begin
                    errors++;
                    $display("FAIL b2b second idx%0d: got x=%0d y=%0d idx=%0d required x=%0d y=%0d", c, rd_x, rd_y, rd_idx, 30 + dx_t[c], 40 + dy_t[c]);
                end
            end
            step();
        end
        checks++;
        if (ndone !== 2) begin
            errors++;
            $display("FAIL b2b done_count: got %0d required 2", ndone);
        end
    endtask

    task automatic test_reset_mid();
        rd_ready = 1'b1;
        accept(60, 70);
        for (int i = 0; i < 7; i++) step();
        checks++;
        if (rd_idx !== 4'd7 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid at7: got idx=%0d valid=%b required idx=7 valid=1", rd_idx, rd_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({rd_valid, busy, done, cand_ready} !== 4'b0001) begin
                errors++;
                $display("FAIL rstmid after c%0d: got %b required 0001", c, {rd_valid, busy, done, cand_ready});
            end
            if (c < 2) step();
        end
        accept(20, 20);
        checks++;
        if ({rd_valid, rd_idx, rd_x, rd_y} !== {1'b1, 4'd0, 10'd20, 9'd17}) begin
            errors++;
            $display("FAIL rstmid restart: got idx=%0d x=%0d y=%0d required idx=0 x=20 y=17", rd_idx, rd_x, rd_y);
        end
        for (int c = 0; c < 18; c++) step();
    endtask

`ifdef RING_BOUNDS_CHECK_EN
    task automatic test_bounds();
        int nvalid = 0;
        rd_ready = 1'b1;
        accept(2, 100);
        checks++;
        if ({done, skip, rd_valid} !== 3'b110) begin
            errors++;
            $display("FAIL bounds skip: got %b required 110", {done, skip, rd_valid});
        end
        for (int c = 0; c < 3; c++) begin
            nvalid += int'(rd_valid);
            step();
        end
        checks++;
        if (nvalid !== 0 || cand_ready !== 1'b1) begin
            errors++;
            $display("FAIL bounds noreads: got reads=%0d ready=%b required reads=0 ready=1", nvalid, cand_ready);
        end
        accept(3, 3);
        checks++;
        if ({rd_valid, rd_x, rd_y, skip} !== {1'b1, 10'd3, 9'd0, 1'b0}) begin
            errors++;
            $display("FAIL bounds edge: got x=%0d y=%0d skip=%b required x=3 y=0 skip=0", rd_x, rd_y, skip);
        end
        for (int c = 0; c < 16; c++) step();
        checks++;
        if ({done, skip} !== 2'b10) begin
            errors++;
            $display("FAIL bounds edge_done: got %b required 10", {done, skip});
        end
        step();
    endtask
`else
    task automatic test_wrap();
        rd_ready = 1'b1;
        accept(0, 0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({rd_valid, rd_idx, rd_x, rd_y} !== {1'b1, 4'(i), XW'(dx_t[i]), YW'(dy_t[i])}) begin
                errors++;
                $display("FAIL wrap idx%0d: got x=%0d y=%0d required x=%0d y=%0d", i, rd_x, rd_y, XW'(dx_t[i]), YW'(dy_t[i]));
            end
            step();
        end
        checks++;
        if ({done, skip} !== 2'b10) begin
            errors++;
            $display("FAIL wrap done: got %b required 10", {done, skip});
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef RING_BOUNDS_CHECK_EN
        test_bounds();
`else
        test_wrap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
